// File: rtl/spi_master.sv
// Mode-0 SPI master: MSB-first 8-bit frames with a byte start/done handshake,
// optional ss hold for bursts and a guard interval that keeps ss high between frames.
module spi_master #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       hold_ss,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GUARD = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  logic [7:0] r_div_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_tx_sh;
  logic [7:0] r_rx_sh;
  logic       r_ss;
  logic       r_sck;
  logic       r_mosi;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_dout;
  logic       r_miso_meta;
  logic       r_miso_sync;

  state_t     w_state_nx;
  logic [7:0] w_div_cnt_nx;
  logic [2:0] w_bit_cnt_nx;
  logic [7:0] w_tx_sh_nx;
  logic [7:0] w_rx_sh_nx;
  logic       w_ss_nx;
  logic       w_sck_nx;
  logic       w_mosi_nx;
  logic       w_busy_nx;
  logic       w_done_nx;
  logic [7:0] w_dout_nx;
  logic       w_phase_end;

  assign w_phase_end = (r_div_cnt == DIV_LAST);

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    w_state_nx   = r_state;
    w_div_cnt_nx = r_div_cnt;
    w_bit_cnt_nx = r_bit_cnt;
    w_tx_sh_nx   = r_tx_sh;
    w_rx_sh_nx   = r_rx_sh;
    w_ss_nx      = r_ss;
    w_sck_nx     = r_sck;
    w_mosi_nx    = r_mosi;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_dout_nx    = r_dout;

    case (r_state)
      ST_IDLE, ST_HOLD: begin
        // HOLD accepts a start exactly like IDLE; ss is simply driven low again, so it never glitches.
        if (start) begin
          w_tx_sh_nx   = din;
          w_mosi_nx    = din[7];
          w_ss_nx      = 1'b0;
          w_bit_cnt_nx = 3'd0;
          w_busy_nx    = 1'b1;
          w_div_cnt_nx = 8'd0;
          w_state_nx   = ST_LOW;
        end else if ((r_state == ST_HOLD) && !hold_ss) begin
          w_ss_nx      = 1'b1;
          w_busy_nx    = 1'b1;
          w_div_cnt_nx = 8'd0;
          w_state_nx   = ST_GUARD;
        end else begin
          w_state_nx   = r_state;
        end
      end
      ST_LOW: begin
        if (w_phase_end) begin
          w_div_cnt_nx = 8'd0;
          w_sck_nx     = 1'b1;
          w_state_nx   = ST_HIGH;
        end else begin
          w_div_cnt_nx = r_div_cnt + 8'd1;
        end
      end
      ST_HIGH: begin
        if (w_phase_end) begin
          w_rx_sh_nx   = {r_rx_sh[6:0], r_miso_sync};
          w_div_cnt_nx = 8'd0;
          w_sck_nx     = 1'b0;
          if (r_bit_cnt == 3'd7) begin
            w_state_nx   = ST_TRAIL;
          end else begin
            w_tx_sh_nx   = {r_tx_sh[6:0], 1'b0};
            w_mosi_nx    = r_tx_sh[6];
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
            w_state_nx   = ST_LOW;
          end
        end else begin
          w_div_cnt_nx = r_div_cnt + 8'd1;
        end
      end
      ST_TRAIL: begin
        if (w_phase_end) begin
          w_div_cnt_nx = 8'd0;
          w_dout_nx    = r_rx_sh;
          w_done_nx    = 1'b1;
          if (hold_ss) begin
            w_busy_nx  = 1'b0;
            w_state_nx = ST_HOLD;
          end else begin
            w_ss_nx    = 1'b1;
            w_state_nx = ST_GUARD;
          end
        end else begin
          w_div_cnt_nx = r_div_cnt + 8'd1;
        end
      end
      ST_GUARD: begin
        if (w_phase_end) begin
          w_div_cnt_nx = 8'd0;
          w_busy_nx    = 1'b0;
          w_state_nx   = ST_IDLE;
        end else begin
          w_div_cnt_nx = r_div_cnt + 8'd1;
        end
      end
      default: begin
        w_div_cnt_nx = 8'd0;
        w_ss_nx      = 1'b1;
        w_sck_nx     = 1'b0;
        w_busy_nx    = 1'b0;
        w_state_nx   = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered-output update; miso crosses in through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_div_cnt   <= 8'd0;
      r_bit_cnt   <= 3'd0;
      r_tx_sh     <= 8'h00;
      r_rx_sh     <= 8'h00;
      r_ss        <= 1'b1;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dout      <= 8'h00;
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_div_cnt   <= w_div_cnt_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_tx_sh     <= w_tx_sh_nx;
      r_rx_sh     <= w_rx_sh_nx;
      r_ss        <= w_ss_nx;
      r_sck       <= w_sck_nx;
      r_mosi      <= w_mosi_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_dout      <= w_dout_nx;
      r_miso_meta <= miso;
      r_miso_sync <= r_miso_meta;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;
  assign ss   = r_ss;
  assign sck  = r_sck;
  assign mosi = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: loopback, slave-model, burst, ignored-start, mid-frame reset
// and fast-divider scenarios, with a queue of expected received bytes.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, hold_a, busy_a, done_a, ss_a, sck_a, mosi_a, miso_a;
  logic [7:0] din_a, dout_a;
  logic       start_b, hold_b, busy_b, done_b, ss_b, sck_b, mosi_b, miso_b;
  logic [7:0] din_b, dout_b;

  bit         loop_a;
  logic       sl_miso;
  logic [7:0] sl_byte;
  int         sl_idx;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         dcnt_a = 0;
  int         dcnt_b = 0;
  logic [7:0] exp_q[$];

  assign miso_a = loop_a ? mosi_a : sl_miso;
  assign miso_b = mosi_b;

  spi_master #(.CLK_DIV(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a), .hold_ss(hold_a),
    .busy(busy_a), .done(done_a), .dout(dout_a), .ss(ss_a), .sck(sck_a),
    .mosi(mosi_a), .miso(miso_a)
  );

  spi_master #(.CLK_DIV(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b), .hold_ss(hold_b),
    .busy(busy_b), .done(done_b), .dout(dout_b), .ss(ss_b), .sck(sck_b),
    .mosi(mosi_b), .miso(miso_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_a === 1'b1) dcnt_a++;
    if (done_b === 1'b1) dcnt_b++;
  end

  // Mode-0 slave: first bit valid at ss fall, next bit after each sck fall.
  always @(negedge ss_a) begin
    sl_idx  = 7;
    sl_miso = sl_byte[7];
  end

  always @(negedge sck_a) begin
    if (!ss_a && sl_idx > 0) begin
      sl_idx  = sl_idx - 1;
      sl_miso = sl_byte[sl_idx];
    end
  end

  task automatic do_start(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin start_b = 1'b1; din_b = d; end
    else     begin start_a = 1'b1; din_a = d; end
    @(negedge clk);
    t0 = cyc;
    start_a = 1'b0; start_b = 1'b0;
    din_a = ~d; din_b = ~d;
  endtask

  task automatic watch_frame(input bit sel, input int div, output int lat, output int first_rise,
                             output int rises, output int bad_runs, output logic [7:0] mb,
                             output bit ss_hi, output bit ss_at_done, output logic [7:0] dout_seen);
    logic p_sck, c_sck, c_ss;
    int   last_edge;
    p_sck = 1'b0; last_edge = t0; lat = -1; first_rise = -1; rises = 0; bad_runs = 0;
    mb = 8'h00; ss_hi = 1'b0; ss_at_done = 1'b0; dout_seen = 8'h00;
    for (int i = 0; i < 20 * div + 40; i++) begin
      @(negedge clk);
      c_sck = sel ? sck_b : sck_a;
      c_ss  = sel ? ss_b : ss_a;
      if (c_sck !== p_sck) begin
        if (cyc - last_edge != div) bad_runs++;
        last_edge = cyc;
        if (c_sck) begin
          rises++;
          if (first_rise < 0) first_rise = cyc - t0;
          mb = {mb[6:0], (sel ? mosi_b : mosi_a)};
        end
        p_sck = c_sck;
      end
      if ((sel ? done_b : done_a) === 1'b1) begin
        lat = cyc - t0; ss_at_done = c_ss; dout_seen = sel ? dout_b : dout_a;
        break;
      end
      if (c_ss !== 1'b0) ss_hi = 1'b1;
    end
  endtask

  task automatic wait_busy_low(input bit sel, output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((sel ? busy_b : busy_a) === 1'b0) begin t = cyc - t0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
    din_a = 8'h00; din_b = 8'h00; loop_a = 1'b1; sl_miso = 1'b0; sl_byte = 8'h00; sl_idx = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ss_a, sck_a, mosi_a, busy_a, done_a} !== 5'b10000 || dout_a !== 8'h00) begin
      failures++;
      $display("FAIL reset_a: ss/sck/mosi/busy/done=%b dout=%h, want 10000 dout=00",
               {ss_a, sck_a, mosi_a, busy_a, done_a}, dout_a);
    end
    checks++;
    if ({ss_b, sck_b, mosi_b, busy_b, done_b} !== 5'b10000 || dout_b !== 8'h00) begin
      failures++;
      $display("FAIL reset_b: ss/sck/mosi/busy/done=%b dout=%h, want 10000 dout=00",
               {ss_b, sck_b, mosi_b, busy_b, done_b}, dout_b);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    int lat, fr, rises, bad, tb_low; logic [7:0] mb, dseen, exp; bit ss_hi, ss_dn;
    loop_a = 1'b1;
    exp_q.push_back(8'hA5);
    do_start(1'b0, 8'hA5);
    checks++;
    if (ss_a !== 1'b0 || busy_a !== 1'b1) begin
      failures++; $display("FAIL lb_start: ss=%b busy=%b, want ss=0 busy=1", ss_a, busy_a);
    end
    watch_frame(1'b0, 8, lat, fr, rises, bad, mb, ss_hi, ss_dn, dseen);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (lat !== 136) begin failures++; $display("FAIL lb_done_lat: got %0d want 136", lat); end
    checks++; if (fr !== 8) begin failures++; $display("FAIL lb_first_rise: got %0d want 8", fr); end
    checks++; if (rises !== 8 || bad !== 0) begin failures++; $display("FAIL lb_sck: rises=%0d bad_runs=%0d want 8/0", rises, bad); end
    checks++; if (ss_hi !== 1'b0 || ss_dn !== 1'b1) begin failures++; $display("FAIL lb_ss: early_high=%b at_done=%b want 0/1", ss_hi, ss_dn); end
    checks++; if (mb !== 8'hA5) begin failures++; $display("FAIL lb_mosi: got %h want a5", mb); end
    checks++; if (dseen !== exp) begin failures++; $display("FAIL lb_dout: got %h want %h", dseen, exp); end
    wait_busy_low(1'b0, tb_low);
    checks++; if (tb_low !== 144) begin failures++; $display("FAIL lb_busy_fall: got %0d want 144", tb_low); end
    repeat (10) @(negedge clk);
    checks++; if (dout_a !== 8'hA5) begin failures++; $display("FAIL lb_dout_hold: got %h want a5", dout_a); end
  endtask

  task automatic test_slave();
    int lat, fr, rises, bad, tb_low; logic [7:0] mb, dseen, exp; bit ss_hi, ss_dn;
    loop_a = 1'b0; sl_byte = 8'h3C;
    exp_q.push_back(8'h3C);
    do_start(1'b0, 8'hC3);
    watch_frame(1'b0, 8, lat, fr, rises, bad, mb, ss_hi, ss_dn, dseen);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (mb !== 8'hC3) begin failures++; $display("FAIL sl_mosi_bits: got %b want 11000011", mb); end
    checks++; if (dseen !== exp || lat !== 136) begin failures++; $display("FAIL sl_dout: got %h lat %0d want %h lat 136", dseen, lat, exp); end
    wait_busy_low(1'b0, tb_low);
    loop_a = 1'b1;
  endtask

  task automatic test_burst();
    int lat, fr, rises, bad, d0, gcnt; logic [7:0] mb, dseen, exp; bit ss_hi, ss_dn, gap_bad;
    loop_a = 1'b1; hold_a = 1'b1; d0 = dcnt_a;
    exp_q.push_back(8'h01);
    do_start(1'b0, 8'h01);
    watch_frame(1'b0, 8, lat, fr, rises, bad, mb, ss_hi, ss_dn, dseen);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (dseen !== exp || lat !== 136) begin failures++; $display("FAIL bu_dout1: got %h lat %0d want %h lat 136", dseen, lat, exp); end
    checks++; if (ss_hi !== 1'b0 || ss_dn !== 1'b0) begin failures++; $display("FAIL bu_ss1: early_high=%b at_done=%b want 0/0", ss_hi, ss_dn); end
    gap_bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ss_a !== 1'b0 || busy_a !== 1'b0) gap_bad = 1'b1;
    end
    checks++; if (gap_bad !== 1'b0) begin failures++; $display("FAIL bu_hold_gap: ss/busy not 0/0 between bytes (flag=%b want 0)", gap_bad); end
    exp_q.push_back(8'h80);
    do_start(1'b0, 8'h80);
    watch_frame(1'b0, 8, lat, fr, rises, bad, mb, ss_hi, ss_dn, dseen);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (dseen !== exp || mb !== 8'h80) begin failures++; $display("FAIL bu_dout2: got %h mosi %h want %h", dseen, mb, exp); end
    checks++; if (ss_hi !== 1'b0 || ss_dn !== 1'b0) begin failures++; $display("FAIL bu_ss2: early_high=%b at_done=%b want 0/0", ss_hi, ss_dn); end
    repeat (5) @(negedge clk);
    checks++; if (ss_a !== 1'b0 || dcnt_a - d0 !== 2) begin failures++; $display("FAIL bu_hold: ss=%b dones=%0d want 0/2", ss_a, dcnt_a - d0); end
    hold_a = 1'b0;
    @(negedge clk);
    checks++; if (ss_a !== 1'b1) begin failures++; $display("FAIL bu_ss_rise: got %b want 1", ss_a); end
    gcnt = 0;
    while (busy_a === 1'b1 && gcnt < 50) begin
      gcnt++;
      @(negedge clk);
    end
    checks++; if (gcnt !== 8) begin failures++; $display("FAIL bu_guard: busy high %0d cycles want 8", gcnt); end
  endtask

  task automatic test_ignore_start();
    int lat, fr, rises, bad, d0, tb_low; logic [7:0] mb, dseen, exp; bit ss_hi, ss_dn;
    loop_a = 1'b1; d0 = dcnt_a;
    exp_q.push_back(8'h96);
    do_start(1'b0, 8'h96);
    fork
      watch_frame(1'b0, 8, lat, fr, rises, bad, mb, ss_hi, ss_dn, dseen);
      begin
        repeat (52) @(negedge clk);
        start_a = 1'b1; din_a = 8'hFF;
        @(negedge clk);
        start_a = 1'b0;
      end
    join
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (dseen !== exp || mb !== 8'h96 || lat !== 136) begin failures++; $display("FAIL ig_frame: dout %h mosi %h lat %0d want %h/96/136", dseen, mb, lat, exp); end
    wait_busy_low(1'b0, tb_low);
    checks++; if (tb_low !== 144) begin failures++; $display("FAIL ig_busy_fall: got %0d want 144", tb_low); end
    repeat (200) @(negedge clk);
    checks++; if (dcnt_a - d0 !== 1 || ss_a !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("FAIL ig_single: dones=%0d ss=%b busy=%b want 1/1/0", dcnt_a - d0, ss_a, busy_a); end
  endtask

  task automatic test_reset_midframe();
    int lat, fr, rises, bad, d0, tb_low; logic [7:0] mb, dseen, exp; bit ss_hi, ss_dn;
    loop_a = 1'b1;
    do_start(1'b0, 8'hFF);
    d0 = dcnt_a;
    repeat (92) @(negedge clk);
    checks++; if (sck_a !== 1'b1 || mosi_a !== 1'b1 || ss_a !== 1'b0) begin failures++; $display("FAIL rm_pre: sck=%b mosi=%b ss=%b want 1/1/0", sck_a, mosi_a, ss_a); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ss_a, sck_a, mosi_a, busy_a} !== 4'b1000 || dout_a !== 8'h00) begin
      failures++; $display("FAIL rm_async: ss/sck/mosi/busy=%b dout=%h want 1000/00", {ss_a, sck_a, mosi_a, busy_a}, dout_a);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (dcnt_a !== d0) begin failures++; $display("FAIL rm_no_done: dones=%0d want %0d", dcnt_a, d0); end
    exp_q.push_back(8'h5A);
    do_start(1'b0, 8'h5A);
    watch_frame(1'b0, 8, lat, fr, rises, bad, mb, ss_hi, ss_dn, dseen);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (dseen !== exp || lat !== 136) begin failures++; $display("FAIL rm_after: dout %h lat %0d want %h/136", dseen, lat, exp); end
    wait_busy_low(1'b0, tb_low);
  endtask

  task automatic test_div4();
    int lat, fr, rises, bad, tb_low; logic [7:0] mb, dseen, exp; bit ss_hi, ss_dn;
    logic [7:0] pats [2];
    pats[0] = 8'hFF; pats[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(pats[k]);
      do_start(1'b1, pats[k]);
      watch_frame(1'b1, 4, lat, fr, rises, bad, mb, ss_hi, ss_dn, dseen);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (lat !== 68) begin failures++; $display("FAIL d4_done_lat[%0d]: got %0d want 68", k, lat); end
      checks++; if (fr !== 4 || rises !== 8 || bad !== 0) begin failures++; $display("FAIL d4_sck[%0d]: first %0d rises %0d bad %0d want 4/8/0", k, fr, rises, bad); end
      checks++; if (dseen !== exp) begin failures++; $display("FAIL d4_dout[%0d]: got %h want %h", k, dseen, exp); end
      wait_busy_low(1'b1, tb_low);
      checks++; if (tb_low !== 72) begin failures++; $display("FAIL d4_busy_fall[%0d]: got %0d want 72", k, tb_low); end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_burst();
    test_ignore_start();
    test_reset_midframe();
    test_div4();
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_empty: %0d left want 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
